easyaxi_slv_rd: RTL and testbench

- Parametrised AXI read slave: generalises the single-request AR-capture slave.
- Accepts up to OST_DEPTH outstanding AR requests, queues them in order and returns full FIXED/INCR bursts on the R channel after a programmable latency.
- Read data is a deterministic address pattern; requests outside the decoded window are either stalled or answered with DECERR.
- Sits at the slave end of the easy_axi fabric as the read-side traffic target for master and interconnect verification.

---
 rtl/easyaxi_slv_rd_pkg.sv | 35 +++
 rtl/easyaxi_slv_rd_fifo.sv | 59 +++++
 rtl/easyaxi_slv_rd.sv | 152 +++++++++++++++
 tb/tb_easyaxi_slv_rd.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/easyaxi_slv_rd_pkg.sv
// easyaxi_slv_rd_pkg: shared AXI burst/resp encodings, default widths and
// the read-engine state type for the easyaxi read slave.
package easyaxi_slv_rd_pkg;

    localparam int unsigned DEF_ID_W   = 4;
    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_DATA_W = 32;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_BURST = 2'd2
    } rd_state_e;

    // Response chosen at AR acceptance: miss -> DECERR, unsupported burst -> SLVERR
    function automatic logic [1:0] ar_resp_f(input logic hit, input logic [1:0] burst);
        if (!hit) begin
            return RESP_DECERR;
        end
        case (burst)
            BURST_FIXED, BURST_INCR: return RESP_OKAY;
            BURST_WRAP:              return RESP_SLVERR;
            default:                 return RESP_SLVERR;
        endcase
    endfunction

endpackage

// File: rtl/easyaxi_slv_rd_fifo.sv
// easyaxi_slv_rd_fifo: in-order request queue, DEPTH entries of W bits.
// Head is presented combinationally on data_o; caller never pushes when
// full nor pops when empty.
module easyaxi_slv_rd_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [W-1:0]             data_i,
    input  logic                     pop_i,
    output logic [W-1:0]             data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] cnt_q;

    // Entry storage; slots are only read after being written
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wptr_q] <= data_i;
        end
    end

    // Pointers wrap naturally modulo DEPTH; occupancy tracks push/pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_i) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (pop_i) begin
                rptr_q <= rptr_q + AW'(1);
            end
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign data_o  = mem_q[rptr_q];
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;

endmodule

// File: rtl/easyaxi_slv_rd.sv
// easyaxi_slv_rd: AXI read slave with an OST_DEPTH-deep in-order AR queue,
// programmable first-beat latency and address-pattern read data.
// Build option EASYAXI_SLV_RD_DECERR_EN: accept out-of-window reads and
// answer them with DECERR beats; when undefined such reads stall on arready.
module easyaxi_slv_rd
    import easyaxi_slv_rd_pkg::*;
#(
    parameter int unsigned       ID_W       = DEF_ID_W,
    parameter int unsigned       ADDR_W     = DEF_ADDR_W,
    parameter int unsigned       DATA_W     = DEF_DATA_W,
    parameter int unsigned       OST_DEPTH  = 4,
    parameter int unsigned       RD_LATENCY = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int unsigned       WIN_SIZE   = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              axi_slv_arvalid,
    output logic              axi_slv_arready,
    input  logic [ID_W-1:0]   axi_slv_arid,
    input  logic [ADDR_W-1:0] axi_slv_araddr,
    input  logic [7:0]        axi_slv_arlen,
    input  logic [1:0]        axi_slv_arburst,
    output logic              axi_slv_rvalid,
    input  logic              axi_slv_rready,
    output logic [ID_W-1:0]   axi_slv_rid,
    output logic [DATA_W-1:0] axi_slv_rdata,
    output logic [1:0]        axi_slv_rresp,
    output logic              axi_slv_rlast
);

    localparam int unsigned       BYTES      = DATA_W / 8;
    localparam int unsigned       LAT_W      = 4;
    localparam int unsigned       CNT_W      = $clog2(OST_DEPTH) + 1;
    localparam int unsigned       ENT_W      = ID_W + ADDR_W + 8 + 2 + 2;
    localparam logic [ADDR_W-1:0] WIN_MASK   = ADDR_W'(WIN_SIZE - 1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(BYTES - 1);

    logic              rst_done_q;
    logic              ar_hit, ar_hs;
    logic [1:0]        ar_resp;
    logic [ENT_W-1:0]  push_data, head_data;
    logic              q_full, q_empty, q_pop;
    logic [CNT_W-1:0]  q_count;
    logic              unused_q_count;
    logic [ID_W-1:0]   h_id;
    logic [ADDR_W-1:0] h_addr;
    logic [7:0]        h_len;
    logic [1:0]        h_burst, h_resp;
    rd_state_e         state_q, state_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [7:0]        beat_q, beat_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              r_hs;

    // AR decode and acceptance; arready never looks at arvalid
    assign ar_hit  = ((axi_slv_araddr & ~WIN_MASK) == BASE_ADDR);
    assign ar_resp = ar_resp_f(ar_hit, axi_slv_arburst);
`ifdef EASYAXI_SLV_RD_DECERR_EN
    assign axi_slv_arready = rst_done_q && enable && !q_full;
`else
    assign axi_slv_arready = rst_done_q && enable && !q_full && ar_hit;
`endif
    assign ar_hs     = axi_slv_arvalid && axi_slv_arready;
    assign push_data = {axi_slv_arid, axi_slv_araddr & ~ALIGN_MASK,
                        axi_slv_arlen, axi_slv_arburst, ar_resp};

    // The head slot stays occupied until its burst completes, so the
    // in-service request counts toward OST_DEPTH
    easyaxi_slv_rd_fifo #(
        .W     (ENT_W),
        .DEPTH (OST_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (ar_hs),
        .data_i  (push_data),
        .pop_i   (q_pop),
        .data_o  (head_data),
        .full_o  (q_full),
        .empty_o (q_empty),
        .count_o (q_count)
    );

    assign {h_id, h_addr, h_len, h_burst, h_resp} = head_data;
    assign unused_q_count = ^q_count;

    // Read engine state register; rst_done_q keeps arready low one cycle past reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            lat_q      <= '0;
            beat_q     <= '0;
            addr_q     <= '0;
            rst_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lat_q      <= lat_d;
            beat_q     <= beat_d;
            addr_q     <= addr_d;
            rst_done_q <= 1'b1;
        end
    end

    // Next-state: IDLE picks up the head, WAIT burns latency, BURST streams beats
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        beat_d  = beat_q;
        addr_d  = addr_q;
        q_pop   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!q_empty) begin
                    addr_d  = h_addr;
                    beat_d  = '0;
                    lat_d   = '0;
                    state_d = (RD_LATENCY <= 1) ? S_BURST : S_WAIT;
                end
            end
            S_WAIT: begin
                lat_d = lat_q + LAT_W'(1);
                if (lat_q == LAT_W'(RD_LATENCY - 2)) begin
                    state_d = S_BURST;
                end
            end
            S_BURST: begin
                if (r_hs) begin
                    beat_d = beat_q + 8'd1;
                    if (h_burst == BURST_INCR) begin
                        addr_d = addr_q + ADDR_W'(BYTES);
                    end
                    if (axi_slv_rlast) begin
                        q_pop   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // R channel decoded from registered state; payload is zero outside a burst
    assign axi_slv_rvalid = (state_q == S_BURST);
    assign r_hs           = axi_slv_rvalid && axi_slv_rready;
    assign axi_slv_rlast  = axi_slv_rvalid && (beat_q == h_len);
    assign axi_slv_rid    = axi_slv_rvalid ? h_id : '0;
    assign axi_slv_rresp  = axi_slv_rvalid ? h_resp : RESP_OKAY;
    assign axi_slv_rdata  = (axi_slv_rvalid && (h_resp == RESP_OKAY)) ? DATA_W'(addr_q) : '0;

endmodule

// File: tb/tb_easyaxi_slv_rd.sv
// tb_easyaxi_slv_rd: directed table-driven bench for easyaxi_slv_rd
// (defaults: ID 4, ADDR/DATA 32, OST_DEPTH 4, RD_LATENCY 4, window [0,0x1000)).
module tb_easyaxi_slv_rd;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        arvalid, arready;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [1:0]  arburst;
    logic        rvalid, rready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [1:0]  burst;
        bit          toggle;
        logic [1:0]  exp_resp;
        logic [31:0] exp_d0;
        logic [31:0] exp_step;
    } vec_t;

    vec_t vecs[$];

    easyaxi_slv_rd dut (
        .clk             (clk),
        .rst             (rst),
        .enable          (enable),
        .axi_slv_arvalid (arvalid),
        .axi_slv_arready (arready),
        .axi_slv_arid    (arid),
        .axi_slv_araddr  (araddr),
        .axi_slv_arlen   (arlen),
        .axi_slv_arburst (arburst),
        .axi_slv_rvalid  (rvalid),
        .axi_slv_rready  (rready),
        .axi_slv_rid     (rid),
        .axi_slv_rdata   (rdata),
        .axi_slv_rresp   (rresp),
        .axi_slv_rlast   (rlast)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // One request on an idle slave: AR handshake, latency, then every beat
    task automatic run_vec(input vec_t v);
        int beat;
        int phase;
        logic [31:0] exp_d;
        @(posedge clk); #1;
        arvalid = 1'b1; arid = v.id; araddr = v.addr; arlen = v.len; arburst = v.burst;
        rready = 1'b0;
        @(negedge clk);
        chk("vec_arready", arready, 1);
        for (int n = 1; n <= LAT; n++) begin
            @(posedge clk); #1;
            arvalid = 1'b0;
            @(negedge clk);
            chk("vec_latency_rvalid", rvalid, 0);
        end
        beat = 0;
        phase = 0;
        while (beat <= int'(v.len) && phase < 600) begin
            @(posedge clk); #1;
            rready = v.toggle ? ((phase % 2) == 0) : 1'b1;
            @(negedge clk);
            exp_d = v.exp_d0 + 32'(beat) * v.exp_step;
            chk("vec_rvalid", rvalid, 1);
            chk("vec_rid", rid, v.id);
            chk("vec_rdata", rdata, exp_d);
            chk("vec_rresp", rresp, v.exp_resp);
            chk("vec_rlast", rlast, (beat == int'(v.len)));
            if (rvalid && rready) beat++;
            phase++;
        end
        chk("vec_beats_done", beat, int'(v.len) + 1);
        @(posedge clk); #1;
        rready = 1'b0;
        @(negedge clk);
        chk("vec_idle_after", rvalid, 0);
    endtask

    initial begin
        int k;
        int idx;
        int guard;
        int nb;
        logic [3:0] exp_ids [4];
        vec_t v;

        // id, addr, len, burst, toggle, resp, first data, data step
        vecs.push_back('{4'd3, 32'h10,  8'd3, 2'b01, 1'b0, 2'b00, 32'h10,  32'd4});
        vecs.push_back('{4'd5, 32'h24,  8'd2, 2'b00, 1'b1, 2'b00, 32'h24,  32'd0});
        vecs.push_back('{4'd7, 32'h40,  8'd3, 2'b10, 1'b0, 2'b10, 32'h0,   32'd0});
        vecs.push_back('{4'd2, 32'h13,  8'd1, 2'b01, 1'b1, 2'b00, 32'h10,  32'd4});
        vecs.push_back('{4'd9, 32'hFF8, 8'd3, 2'b01, 1'b0, 2'b00, 32'hFF8, 32'd4});
        vecs.push_back('{4'd1, 32'h100, 8'd0, 2'b11, 1'b0, 2'b10, 32'h0,   32'd0});
`ifdef EASYAXI_SLV_RD_DECERR_EN
        vecs.push_back('{4'd6, 32'h2000, 8'd1, 2'b01, 1'b0, 2'b11, 32'h0,  32'd0});
`endif

        // Reset: every output low, even with enable high and a hit address
        rst = 1'b1; enable = 1'b1; arvalid = 1'b0; arid = '0; araddr = '0;
        arlen = '0; arburst = 2'b01; rready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_arready", arready, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_rid", rid, 0);
        chk("rst_rresp", rresp, 0);
        chk("rst_rlast", rlast, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_arready", arready, 0);

        // enable low blocks acceptance
        @(posedge clk); #1;
        enable = 1'b0; arvalid = 1'b1; araddr = 32'h10;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("disabled_arready", arready, 0);
            @(posedge clk); #1;
        end
        arvalid = 1'b0; enable = 1'b1;
        @(negedge clk);
        chk("enabled_arready", arready, 1);

        // Table of single requests
        foreach (vecs[i]) run_vec(vecs[i]);

        // Queue fill: four pushes with rready low, fifth stalls until first rlast
        rready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            arvalid = 1'b1; arid = 4'(i + 1); araddr = 32'h100 + 32'(i) * 32'h40;
            arlen = 8'd0; arburst = 2'b01;
            @(negedge clk);
            chk("fill_arready", arready, 1);
        end
        @(posedge clk); #1;
        arid = 4'd5; araddr = 32'h200;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("full_arready", arready, 0);
            @(posedge clk); #1;
        end
        rready = 1'b1;
        @(negedge clk);
        chk("full_first_rvalid", rvalid, 1);
        chk("full_first_rid", rid, 1);
        chk("full_first_rlast", rlast, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("refill_arready", arready, 1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        exp_ids[0] = 4'd2; exp_ids[1] = 4'd3; exp_ids[2] = 4'd4; exp_ids[3] = 4'd5;
        idx = 0;
        guard = 0;
        while (idx < 4 && guard < 200) begin
            @(negedge clk);
            if (rvalid && rready) begin
                chk("order_rid", rid, exp_ids[idx]);
                chk("order_rdata", rdata, (idx < 3) ? 32'h100 + 32'(idx + 1) * 32'h40 : 32'h200);
                idx++;
            end
            guard++;
        end
        chk("order_count", idx, 4);
        @(posedge clk); #1;
        rready = 1'b0;

`ifndef EASYAXI_SLV_RD_DECERR_EN
        // Miss stalls: arready stays low and nothing is returned
        @(posedge clk); #1;
        arvalid = 1'b1; arid = 4'd6; araddr = 32'h2000; arlen = 8'd1; arburst = 2'b01;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("miss_arready", arready, 0);
            chk("miss_rvalid", rvalid, 0);
            @(posedge clk); #1;
        end
        arvalid = 1'b0;
`endif

        // Reset during beat 2 of an 8-beat burst with a second request queued
        @(posedge clk); #1;
        arvalid = 1'b1; arid = 4'hA; araddr = 32'h200; arlen = 8'd7; arburst = 2'b01;
        rready = 1'b1;
        @(negedge clk);
        chk("rstseq_ar_a", arready, 1);
        @(posedge clk); #1;
        arid = 4'hB; araddr = 32'h300; arlen = 8'd0;
        @(negedge clk);
        chk("rstseq_ar_b", arready, 1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        nb = 0;
        guard = 0;
        while (nb < 2 && guard < 50) begin
            @(negedge clk);
            if (rvalid && rready) nb++;
            guard++;
        end
        chk("rstseq_two_beats", nb, 2);
        @(negedge clk);
        chk("rstseq_beat2_rdata", rdata, 32'h208);
        chk("rstseq_beat2_rid", rid, 4'hA);
        #1 rst = 1'b1;
        #1;
        chk("rstseq_rvalid_drop", rvalid, 0);
        chk("rstseq_rdata_drop", rdata, 0);
        chk("rstseq_rlast_drop", rlast, 0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("rstseq_queue_empty", rvalid, 0);
        end
        v = '{4'hC, 32'h80, 8'd1, 2'b01, 1'b0, 2'b00, 32'h80, 32'd4};
        run_vec(v);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
